// File: rtl/i2c_codec_target_pkg.sv
// Shared constants for the codec control-port target: device address, register map, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_codec_target_pkg;

    localparam logic [6:0] CODEC_DEV_ADDR  = 7'h1A;
    localparam int         CODEC_NUM_REGS  = 10;
    localparam logic [6:0] CODEC_RESET_REG = 7'd15;

    // Codec register map, indices 0..9
    localparam logic [3:0] REG_LIN_L    = 4'd0;
    localparam logic [3:0] REG_LIN_R    = 4'd1;
    localparam logic [3:0] REG_HP_L     = 4'd2;
    localparam logic [3:0] REG_HP_R     = 4'd3;
    localparam logic [3:0] REG_ANALOG   = 4'd4;
    localparam logic [3:0] REG_DIGITAL  = 4'd5;
    localparam logic [3:0] REG_POWER    = 4'd6;
    localparam logic [3:0] REG_FORMAT   = 4'd7;
    localparam logic [3:0] REG_SAMPLING = 4'd8;
    localparam logic [3:0] REG_ACTIVE   = 4'd9;

    // Frame FSM encoding
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_ADDR      = 4'd1;
    localparam state_t ST_ACK_A     = 4'd2;
    localparam state_t ST_BYTE_H    = 4'd3;
    localparam state_t ST_ACK_H     = 4'd4;
    localparam state_t ST_BYTE_L    = 4'd5;
    localparam state_t ST_ACK_L     = 4'd6;
    localparam state_t ST_WAIT_STOP = 4'd7;
    localparam state_t ST_IGNORE    = 4'd8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA pads and flags START, STOP, SCL rise and SCL fall as 1-cycle strobes.
// Latency: 3 clk from a pad edge to the registered strobe.
// Backpressure: none; strobes are fire-and-forget, the consumer must act in the strobe cycle.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    // Two-flop synchronizers plus one delay stage; reset to bus-idle (high) so release of reset raises no false START
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_d    <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_s1   <= scl_i;
            scl_s2   <= scl_s1;
            scl_d    <= scl_s2;
            sda_s1   <= sda_i;
            sda_s2   <= sda_s1;
            sda_d    <= sda_s2;
            scl_rise <= scl_s2 & ~scl_d;
            scl_fall <= ~scl_s2 & scl_d;
            start    <= scl_s2 & scl_d & sda_d & ~sda_s2;
            stop     <= scl_s2 & scl_d & ~sda_d & sda_s2;
        end
    end

    // sda_d lines up with the registered scl_rise strobe
    assign sda = sda_d;

endmodule

// File: rtl/i2c_codec_target.sv
// I2C write-only target emulating the codec control port; 3-byte frames land in a 9-bit register file.
// Latency: reg_wr_o 1 clk after the detected 9th SCL rise of the data byte; rd_data_o 1 clk after rd_addr_i.
// Backpressure: none on the bus side beyond ACK/NACK; unsupported addresses and extra bytes are NACKed.
module i2c_codec_target
    import i2c_codec_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = CODEC_DEV_ADDR,
    parameter int         NUM_REGS = CODEC_NUM_REGS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       reg_wr_o,
    output logic [6:0] reg_addr_o,
    output logic [8:0] reg_data_o,
    input  logic [3:0] rd_addr_i,
    output logic [8:0] rd_data_o,
    output logic       active_o,
    output logic       busy_o
);

    localparam logic [6:0] ADDR_LIMIT = 7'(NUM_REGS);
    localparam logic [3:0] RD_LIMIT   = 4'(NUM_REGS);

    logic       sda_bit, scl_rise, scl_fall, start, stop;
    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shreg;
    logic [6:0] addr_q;
    logic       data_hi;
    logic [8:0] wr_data;
    logic       commit;
    logic [8:0] regs [NUM_REGS];

    i2c_line_sync u_line_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda_bit),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign wr_data = {data_hi, shreg};
    // A START/STOP in the same cycle abandons the frame, so it also blocks the commit
    assign commit  = (state == ST_ACK_L) && scl_rise && !start && !stop;

    // Frame FSM: shifts bytes on SCL rise, moves the ACK driver only on SCL fall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            shreg    <= 8'd0;
            addr_q   <= 7'd0;
            data_hi  <= 1'b0;
            sda_oe_o <= 1'b0;
        end else if (stop) begin
            state    <= ST_IDLE;
            sda_oe_o <= 1'b0;
        end else if (start) begin
            state    <= ST_ADDR;
            bit_cnt  <= 4'd0;
            sda_oe_o <= 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_BYTE_H, ST_BYTE_L: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shreg   <= {shreg[6:0], sda_bit};
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (state == ST_ADDR) begin
                            if (shreg == {DEV_ADDR, 1'b0}) begin
                                state    <= ST_ACK_A;
                                sda_oe_o <= 1'b1;
                            end else begin
                                state    <= ST_IGNORE;
                            end
                        end else if (state == ST_BYTE_H) begin
                            addr_q   <= shreg[7:1];
                            data_hi  <= shreg[0];
                            state    <= ST_ACK_H;
                            sda_oe_o <= 1'b1;
                        end else begin
                            // The reset register sits outside the map but is always accepted
                            if (addr_q < ADDR_LIMIT || addr_q == CODEC_RESET_REG) begin
                                state    <= ST_ACK_L;
                                sda_oe_o <= 1'b1;
                            end else begin
                                state    <= ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ACK_A, ST_ACK_H: begin
                    if (scl_fall) begin
                        sda_oe_o <= 1'b0;
                        bit_cnt  <= 4'd0;
                        state    <= (state == ST_ACK_A) ? ST_BYTE_H : ST_BYTE_L;
                    end
                end
                ST_ACK_L: begin
                    // ACK stays driven through the 9th clock; WAIT_STOP releases it on the next fall
                    if (scl_rise) begin
                        state <= ST_WAIT_STOP;
                    end
                end
                ST_WAIT_STOP: begin
                    if (scl_fall) begin
                        sda_oe_o <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register file and commit outputs; the reset command wipes the whole map
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 9'd0;
            end
            reg_wr_o   <= 1'b0;
            reg_addr_o <= 7'd0;
            reg_data_o <= 9'd0;
        end else begin
            reg_wr_o <= commit;
            if (commit) begin
                reg_addr_o <= addr_q;
                reg_data_o <= wr_data;
                if (addr_q == CODEC_RESET_REG) begin
                    if (wr_data == 9'd0) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            regs[i] <= 9'd0;
                        end
                    end
                end else begin
                    regs[addr_q[3:0]] <= wr_data;
                end
            end
        end
    end

    // Registered readback; a same-cycle write is seen on the following read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_o <= 9'd0;
        end else begin
            rd_data_o <= (rd_addr_i < RD_LIMIT) ? regs[rd_addr_i] : 9'd0;
        end
    end

    assign active_o = regs[REG_ACTIVE][0];
    assign busy_o   = (state != ST_IDLE);

endmodule
